// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  localparam int RW_DEF = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic pc_le;
    logic if_id_le;
    logic if_id_clr;
    logic id_nop;
    logic pipe_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{pc_le: 1'b0, if_id_le: 1'b0, if_id_clr: 1'b1,
                                   id_nop: 1'b1, pipe_hold: 1'b0};

  // Steady per-state control word; the RUN-state squash/stall overlay is applied in the top.
  function automatic ctrl_t state_ctrl(input state_e st);
    ctrl_t c;
    c = '{pc_le: 1'b1, if_id_le: 1'b1, if_id_clr: 1'b0, id_nop: 1'b0, pipe_hold: 1'b0};
    case (st)
      FLUSH: begin
        c.if_id_clr = 1'b1;
        c.id_nop    = 1'b1;
      end
      FREEZE: begin
        c.pc_le     = 1'b0;
        c.if_id_le  = 1'b0;
        c.pipe_hold = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// rtl/pipeline_hazard_ctrl_fwd_select.sv - priority match of one ID source against EX/MEM/WB destinations
module fwd_select
  import hazard_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] src_i,
  input  logic          src_use_i,
  input  logic [RW-1:0] ex_rd_i,
  input  logic          ex_le_i,
  input  logic [RW-1:0] mem_rd_i,
  input  logic          mem_le_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic          wb_le_i,
  output logic [1:0]    sel_o
);

  logic live;

  // GR0 always reads zero, so it never takes a forwarded value.
  assign live = src_use_i && (src_i != '0);

  always_comb begin
    sel_o = FWD_RF;
    if (live && ex_le_i && (ex_rd_i == src_i)) begin
      sel_o = FWD_EX;
    end else if (live && mem_le_i && (mem_rd_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (live && wb_le_i && (wb_rd_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush, RAM freeze and forwarding control
// Optional per-state cycle counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RW        = RW_DEF,
  parameter int FLUSH_CYC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] id_ra,
  input  logic [RW-1:0] id_rb,
  input  logic          id_ra_use,
  input  logic          id_rb_use,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_l,
  input  logic          ex_rf_le,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_rf_le,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_rf_le,
  input  logic          br_taken,
  input  logic          ram_busy,
  output logic          pc_le,
  output logic          if_id_le,
  output logic          if_id_clr,
  output logic          id_nop,
  output logic          pipe_hold,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt,
  output logic [15:0]   freeze_cnt
`endif
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC - 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [1:0] cnt_q, cnt_d;
  logic       init_q;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl;
  logic       lu;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  fwd_select #(.RW(RW)) u_fwd_a (
    .src_i    (id_ra),
    .src_use_i(id_ra_use),
    .ex_rd_i  (ex_rd),
    .ex_le_i  (ex_rf_le),
    .mem_rd_i (mem_rd),
    .mem_le_i (mem_rf_le),
    .wb_rd_i  (wb_rd),
    .wb_le_i  (wb_rf_le),
    .sel_o    (fwd_a_raw)
  );

  fwd_select #(.RW(RW)) u_fwd_b (
    .src_i    (id_rb),
    .src_use_i(id_rb_use),
    .ex_rd_i  (ex_rd),
    .ex_le_i  (ex_rf_le),
    .mem_rd_i (mem_rd),
    .mem_le_i (mem_rf_le),
    .wb_rd_i  (wb_rd),
    .wb_le_i  (wb_rf_le),
    .sel_o    (fwd_b_raw)
  );

  assign lu = ex_l && ex_rf_le && (ex_rd != '0) &&
              ((id_ra_use && (ex_rd == id_ra)) || (id_rb_use && (ex_rd == id_rb)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    case (state_q)
      RUN, STALL: begin
        if (ram_busy) begin
          state_d = FREEZE;
          ret_d   = state_q;
        end else if (br_taken) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if ((state_q == RUN) && lu) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // A frozen flush resumes with its remaining count untouched.
        if (ram_busy) begin
          state_d = FREEZE;
          ret_d   = FLUSH;
        end else if (br_taken) begin
          cnt_d = FLUSH_LOAD;
        end else if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      FREEZE: begin
        if (!ram_busy) begin
          state_d = ret_q;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= 2'd0;
      init_q  <= 1'b1;
      ctrl_q  <= CTRL_RESET;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b0;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // Squash and load-use stall take effect in the same cycle the condition is seen.
  always_comb begin
    ctrl = ctrl_q;
    if (!init_q && (state_q == RUN)) begin
      if (br_taken) begin
        ctrl.if_id_clr = 1'b1;
        ctrl.id_nop    = 1'b1;
      end else if (lu) begin
        ctrl.pc_le    = 1'b0;
        ctrl.if_id_le = 1'b0;
        ctrl.id_nop   = 1'b1;
      end
    end
  end

  assign pc_le     = ctrl.pc_le;
  assign if_id_le  = ctrl.if_id_le;
  assign if_id_clr = ctrl.if_id_clr;
  assign id_nop    = ctrl.id_nop;
  assign pipe_hold = ctrl.pipe_hold;
  assign fwd_a     = init_q ? FWD_RF : fwd_a_raw;
  assign fwd_b     = init_q ? FWD_RF : fwd_b_raw;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
      freeze_cnt_q <= 16'd0;
    end else begin
      if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if ((state_q == FLUSH) && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
      if ((state_q == FREEZE) && (freeze_cnt_q != 16'hFFFF)) begin
        freeze_cnt_q <= freeze_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;

  localparam int RW        = 5;
  localparam int FLUSH_CYC = 2;
  localparam int RUN_S = 0, STALL_S = 1, FLUSH_S = 2, FREEZE_S = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [RW-1:0] id_ra, id_rb, ex_rd, mem_rd, wb_rd;
  logic          id_ra_use, id_rb_use, ex_l, ex_rf_le, mem_rf_le, wb_rf_le;
  logic          br_taken, ram_busy;
  logic          pc_le, if_id_le, if_id_clr, id_nop, pipe_hold;
  logic [1:0]    fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [15:0]   stall_cnt, flush_cnt, freeze_cnt;
`endif

  pipeline_hazard_ctrl #(.RW(RW), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .id_ra     (id_ra),
    .id_rb     (id_rb),
    .id_ra_use (id_ra_use),
    .id_rb_use (id_rb_use),
    .ex_rd     (ex_rd),
    .ex_l      (ex_l),
    .ex_rf_le  (ex_rf_le),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_rf_le),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_rf_le),
    .br_taken  (br_taken),
    .ram_busy  (ram_busy),
    .pc_le     (pc_le),
    .if_id_le  (if_id_le),
    .if_id_clr (if_id_clr),
    .id_nop    (id_nop),
    .pipe_hold (pipe_hold),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .freeze_cnt(freeze_cnt)
`endif
  );

  wire [4:0] ctrl_v = {pc_le, if_id_le, if_id_clr, id_nop, pipe_hold};

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Model: current mode, flush cycles still owed, mode to resume after a freeze.
  int m_st   = RUN_S;
  int m_left = 0;
  int m_back = RUN_S;
  bit m_init = 1'b1;
  int m_stall_n = 0, m_flush_n = 0, m_freeze_n = 0;

  function automatic bit m_lu();
    bit hit;
    hit = 1'b0;
    if (ex_l && ex_rf_le && (ex_rd != 0)) begin
      hit = (id_ra_use && (id_ra == ex_rd)) || (id_rb_use && (id_rb == ex_rd));
    end
    return hit;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [RW-1:0] src, input logic used);
    logic [RW-1:0] rd [3];
    logic          le [3];
    logic [1:0]    r;
    rd[0] = ex_rd;    rd[1] = mem_rd;    rd[2] = wb_rd;
    le[0] = ex_rf_le; le[1] = mem_rf_le; le[2] = wb_rf_le;
    r = 2'd0;
    if (!m_init && used && (src != 0)) begin
      for (int i = 2; i >= 0; i--) begin
        if (le[i] && (rd[i] == src)) r = 2'(i + 1);
      end
    end
    return r;
  endfunction

  // {pc_le, if_id_le, if_id_clr, id_nop, pipe_hold}
  function automatic logic [4:0] m_ctrl();
    logic [4:0] r;
    r = 5'b11000;
    if (m_init) r = 5'b00110;
    else if (m_st == FLUSH_S) r = 5'b11110;
    else if (m_st == FREEZE_S) r = 5'b00001;
    else if (m_st == RUN_S) begin
      if (br_taken) r = 5'b11110;
      else if (m_lu()) r = 5'b00010;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit lu_now;
    lu_now = m_lu();
    if (reset) begin
      m_st = RUN_S; m_left = 0; m_back = RUN_S; m_init = 1'b1;
      m_stall_n = 0; m_flush_n = 0; m_freeze_n = 0;
    end else begin
      m_init = 1'b0;
      if (m_st == STALL_S && m_stall_n < 65535) m_stall_n++;
      if (m_st == FLUSH_S && m_flush_n < 65535) m_flush_n++;
      if (m_st == FREEZE_S && m_freeze_n < 65535) m_freeze_n++;
      if (m_st == FREEZE_S) begin
        if (!ram_busy) m_st = m_back;
      end else if (ram_busy) begin
        m_back = m_st;
        m_st   = FREEZE_S;
      end else if (br_taken) begin
        m_st   = FLUSH_S;
        m_left = FLUSH_CYC;
      end else if (m_st == FLUSH_S) begin
        m_left = m_left - 1;
        if (m_left == 0) m_st = RUN_S;
      end else if (m_st == RUN_S && lu_now) begin
        m_st = STALL_S;
      end else begin
        m_st = RUN_S;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] ec;
      logic [3:0] ef;
      cyc++;
      ec = m_ctrl();
      ef = {m_fwd(id_ra, id_ra_use), m_fwd(id_rb, id_rb_use)};
      n_checks++;
      if (ctrl_v !== ec) begin
        n_errors++;
        $display("FAIL model_ctrl cyc=%0d got=%b want=%b", cyc, ctrl_v, ec);
      end
      n_checks++;
      if ({fwd_a, fwd_b} !== ef) begin
        n_errors++;
        $display("FAIL model_fwd cyc=%0d got=%b want=%b", cyc, {fwd_a, fwd_b}, ef);
      end
    end
  end

  task automatic lit(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic quiet();
    reset = 1'b0; br_taken = 1'b0; ram_busy = 1'b0;
    id_ra = '0; id_rb = '0; id_ra_use = 1'b0; id_rb_use = 1'b0;
    ex_rd = '0; ex_l = 1'b0; ex_rf_le = 1'b0;
    mem_rd = '0; mem_rf_le = 1'b0; wb_rd = '0; wb_rf_le = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic load_use_r5();
    ex_rd = 5'd5; ex_l = 1'b1; ex_rf_le = 1'b1; id_rb = 5'd5; id_rb_use = 1'b1;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    next();
    chk_en = 1'b1;
    next();
    reset = 1'b0; id_ra = 5'd3; id_ra_use = 1'b1; ex_rd = 5'd3; ex_rf_le = 1'b1;
    settle();
    lit("init_ctrl", ctrl_v, 5'b00110);
    lit("init_fwd_a", {3'b0, fwd_a}, 5'd0);
    next(); settle();
    lit("ex_fwd_a", {3'b0, fwd_a}, 5'd1);
    lit("ex_fwd_ctrl", ctrl_v, 5'b11000);
    next(); id_ra = 5'd0; ex_rd = 5'd0; settle();
    lit("gr0_fwd_a", {3'b0, fwd_a}, 5'd0);
    next(); id_ra = 5'd3; ex_rd = 5'd3; ex_rf_le = 1'b0;
    mem_rd = 5'd3; mem_rf_le = 1'b1; wb_rd = 5'd3; wb_rf_le = 1'b1; settle();
    lit("mem_fwd_a", {3'b0, fwd_a}, 5'd2);
    next(); mem_rf_le = 1'b0; settle();
    lit("wb_fwd_a", {3'b0, fwd_a}, 5'd3);

    next(); quiet(); load_use_r5(); settle();
    lit("lu_ctrl", ctrl_v, 5'b00010);
    next(); quiet(); mem_rd = 5'd5; mem_rf_le = 1'b1; id_rb = 5'd5; id_rb_use = 1'b1; settle();
    lit("stall_fwd_b", {3'b0, fwd_b}, 5'd2);
    lit("stall_ctrl", ctrl_v, 5'b11000);

    next(); quiet(); br_taken = 1'b1; settle();
    lit("br_squash", ctrl_v, 5'b11110);
    next(); quiet(); settle(); lit("flush1", ctrl_v, 5'b11110);
    next(); settle(); lit("flush2", ctrl_v, 5'b11110);
    next(); settle(); lit("flush_done", ctrl_v, 5'b11000);

    next(); br_taken = 1'b1;
    next(); br_taken = 1'b0; ram_busy = 1'b1; settle();
    lit("busy_in_flush", ctrl_v, 5'b11110);
    next(); settle(); lit("freeze1", ctrl_v, 5'b00001);
    next(); settle(); lit("freeze2", ctrl_v, 5'b00001);
    next(); ram_busy = 1'b0; settle(); lit("freeze3", ctrl_v, 5'b00001);
    next(); settle(); lit("resume_flush1", ctrl_v, 5'b11110);
    next(); settle(); lit("resume_flush2", ctrl_v, 5'b11110);
    next(); settle(); lit("resume_run", ctrl_v, 5'b11000);

    next(); quiet(); br_taken = 1'b1; load_use_r5(); settle();
    lit("br_lu_ctrl", ctrl_v, 5'b11110);
    next(); quiet(); settle();
    lit("br_lu_flush", ctrl_v, 5'b11110);
    next(); next();
    br_taken = 1'b1; ram_busy = 1'b1; load_use_r5(); settle();
    lit("all3_ctrl", ctrl_v, 5'b11110);
    next(); quiet(); ram_busy = 1'b1; settle();
    lit("all3_freeze", ctrl_v, 5'b00001);
    next(); reset = 1'b1; settle();
    lit("rst_pending", ctrl_v, 5'b00001);
    next(); reset = 1'b0; ram_busy = 1'b0; settle();
    lit("rst_from_freeze", ctrl_v, 5'b00110);
    next(); settle();
    lit("rst_release_run", ctrl_v, 5'b11000);

    for (int i = 0; i < 4000; i++) begin
      next();
      reset     = ($urandom_range(0, 99) == 0);
      ram_busy  = ($urandom_range(0, 4) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      id_ra     = RW'($urandom_range(0, 3));
      id_rb     = RW'($urandom_range(0, 3));
      id_ra_use = 1'($urandom_range(0, 1));
      id_rb_use = 1'($urandom_range(0, 1));
      ex_rd     = RW'($urandom_range(0, 3));
      ex_l      = ($urandom_range(0, 2) == 0);
      ex_rf_le  = 1'($urandom_range(0, 1));
      mem_rd    = RW'($urandom_range(0, 3));
      mem_rf_le = 1'($urandom_range(0, 1));
      wb_rd     = RW'($urandom_range(0, 3));
      wb_rf_le  = 1'($urandom_range(0, 1));
    end
    next(); quiet(); settle();

`ifdef HAZARD_STATS_EN
    n_checks++;
    if ({stall_cnt, flush_cnt, freeze_cnt} !== {16'(m_stall_n), 16'(m_flush_n), 16'(m_freeze_n)}) begin
      n_errors++;
      $display("FAIL stats got=%0d/%0d/%0d want=%0d/%0d/%0d", stall_cnt, flush_cnt, freeze_cnt,
               m_stall_n, m_flush_n, m_freeze_n);
    end
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Control end of the 5-stage pipeline register chain (PC front/back, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Consumes the destination, load and write-enable fields carried out of ID/EX, EX/MEM and MEM/WB, plus the EX branch outcome.
- Drives the load-enable, clear, bubble and forwarding-select inputs of those registers and of the ID operand muxes.
- Resolves load-use stalls, taken-branch flushes and multi-cycle RAM waits with a small registered FSM.

Parameters:
- RW, 5, register-address width.
- FLUSH_CYC, 1, number of cycles IF/ID is cleared after a taken branch (1..3).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- id_ra  in  RW  ID source address A
- id_rb  in  RW  ID source address B
- id_ra_use  in  1  ID instruction reads A
- id_rb_use  in  1  ID instruction reads B
- ex_rd  in  RW  ID/EX destination
- ex_l  in  1  ID/EX load flag
- ex_rf_le  in  1  ID/EX register-file write enable
- mem_rd  in  RW  EX/MEM destination
- mem_rf_le  in  1  EX/MEM register-file write enable
- wb_rd  in  RW  MEM/WB destination
- wb_rf_le  in  1  MEM/WB register-file write enable
- br_taken  in  1  EX branch/jump resolved taken
- ram_busy  in  1  data RAM not ready this cycle
- pc_le  out  1  PC front/back load enable
- if_id_le  out  1  IF/ID load enable
- if_id_clr  out  1  IF/ID clear
- id_nop  out  1  select NOP control word into ID/EX
- pipe_hold  out  1  hold ID/EX, EX/MEM, MEM/WB
- fwd_a  out  2  A operand source: 00 RF, 01 EX, 10 MEM, 11 WB
- fwd_b  out  2  same encoding for B

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset outputs: while reset is sampled high and on the first cycle after, state is RUN and outputs are:
  - pc_le=0, if_id_le=0, if_id_clr=1, id_nop=1, pipe_hold=0, fwd_a=fwd_b=00.
  - Flush counter = 0.
- Forwarding (combinational, every state):
  - A source matches a stage when the source is used, its address is nonzero, it equals that stage's rd, and that stage's rf_le=1.
  - Priority is EX > MEM > WB > RF.
  - Address 0 is never forwarded; GR0 reads 0.
  - fwd_b follows the same rule.
- Load-use hazard: lu = ex_l & ex_rf_le & (ex_rd != 0) & ((id_ra_use & ex_rd == id_ra) | (id_rb_use & ex_rd == id_rb)).
- States: RUN, STALL, FLUSH, FREEZE. Evaluated in RUN, priority order:
  - ram_busy: FREEZE.
  - Else br_taken: FLUSH, and the counter loads FLUSH_CYC-1.
  - Else lu: STALL.
  - Else stay in RUN.
- RUN outputs: pc_le=1, if_id_le=1, if_id_clr=0, id_nop=0, pipe_hold=0.
  - On the cycle br_taken is seen, outputs are already if_id_clr=1 and id_nop=1 (zero-latency squash).
  - On the cycle lu is seen, outputs are already pc_le=0, if_id_le=0, id_nop=1.
- STALL lasts exactly one cycle.
  - Outputs equal RUN outputs.
  - The load is now in MEM, so the operand forwards from MEM.
  - Next state is RUN, or FREEZE if ram_busy, or FLUSH if br_taken.
  - lu is not re-evaluated in the STALL cycle.
- FLUSH:
  - Outputs: if_id_clr=1, id_nop=1, pc_le=1.
  - Counter decrements each cycle; at 0, next state is RUN.
  - ram_busy preempts to FREEZE; the counter value is kept.
  - A new br_taken reloads the counter.
- FREEZE:
  - Outputs: pc_le=0, if_id_le=0, pipe_hold=1, id_nop=0, if_id_clr=0.
  - Stays while ram_busy is high.
  - On release, returns to the state saved on entry (RUN/STALL/FLUSH, stored in a 2-bit return register).
- Simultaneous events: ram_busy > br_taken > lu.
- Reset mid-operation: any state goes to RUN next cycle; the counter and return register clear.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined:
  - Adds outputs stall_cnt[15:0], flush_cnt[15:0], freeze_cnt[15:0].
  - Each counts cycles spent in STALL, FLUSH and FREEZE respectively.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - State enum (RUN=0, STALL=1, FLUSH=2, FREEZE=3).
  - Forward-select constants FWD_RF/FWD_EX/FWD_MEM/FWD_WB.
  - Default RW.
- One sub-module, fwd_select: the pure combinational priority match, instantiated twice (A and B).

Test Plan:
- EX rd=3, ex_rf_le=1, ex_l=0; ID reads ra=3 -> fwd_a=01, no stall. Same with rd=0 -> fwd_a=00.
- Load r5 in EX, ID reads rb=5 -> one cycle pc_le=0, id_nop=1; next cycle fwd_b=10, pc_le=1.
- br_taken pulse, FLUSH_CYC=2 -> if_id_clr=1 for 2 cycles, then RUN.
- ram_busy high 3 cycles during FLUSH -> pipe_hold=1 for 3 cycles, then remaining flush cycle completes.
- br_taken and lu together -> flush only, no STALL entered. ram_busy together with both -> FREEZE first.
- reset asserted in FREEZE -> next cycle the reset output values; after release, RUN and pc_le=1.
